pwr_trans_monitor: RTL
======================

Name: pwr_trans_monitor

Overview:
- Synthesizable, parametrised successor to the bench-side transition-count memory used for power estimation (CALCULOPOTENCIA flow).
- Watches NCH data channels of W bits each, for example the 8/16/32-bit transmitter/receiver outputs.
- Accumulates per-channel bit-toggle counts in saturating counters.
- Exposes the counts through an addressed read port with a valid strobe, replacing the bench's LE/dir/dato tri-state access.

Parameters:
- NCH, 4: number of monitored channels.
- W, 8: bits per channel sample.
- CW, 32: counter width.
- AW, 3: read-address width; must satisfy 2**AW > NCH.

Ports:
- clk  input  1  single clock, all flops rising-edge.
- rst  input  1  asynchronous, active-low reset.
- enb  input  1  global count enable.
- sample_vld  input  NCH  per-channel sample strobe.
- data_in  input  NCH*W  channel c occupies bits [c*W+W-1 : c*W].
- clr  input  1  synchronous clear of all counters.
- rd_req  input  1  read request, single-cycle pulse.
- rd_addr  input  AW  channel index to read.
- rd_data  output  CW  read result.
- rd_vld  output  1  rd_data valid, one-cycle pulse.
- rd_err  output  1  address out of range, valid with rd_vld.
- sat  output  NCH  sticky saturation flag per channel.

Behaviour:
- Reset (rst=0, asynchronous):
  - All counters, prev-sample registers and primed bits go to 0.
  - Outputs: rd_data=0, rd_vld=0, rd_err=0, sat=0.
- Per channel c, the state is prev[c] (W bits), primed[c] and cnt[c] (CW bits).
- Sample acceptance: a sample on channel c is accepted on a rising edge where enb=1, sample_vld[c]=1 and clr=0.
  - If primed[c]=0: prev[c] <= sample and primed[c] <= 1. No count; the first sample after reset or clear only primes.
  - If primed[c]=1: t = popcount(prev[c] ^ sample), with t in 0..W; prev[c] <= sample.
  - Counter update: cnt[c] <= min(cnt[c]+t, 2**CW-1). Compute the sum at CW+1 bits and clamp.
  - Latency: the count is visible to a read issued the cycle after the accepting edge.
- sat[c] sets when the clamped value equals 2**CW-1 and stays set until clr or reset.
- enb=0: no channel updates; prev and primed hold, so toggles across the disabled window are counted at the next accepted sample.
- clr=1, synchronous, highest priority:
  - cnt, sat and primed all go to 0.
  - Samples in the same cycle are ignored and do not prime.
  - A rd_req in the same cycle returns the pre-clear value.
- Read, one-cycle latency:
  - rd_req=1 at edge k gives rd_vld=1 at edge k+1, with rd_data = cnt[rd_addr] as it stood before edge k's update.
  - Read-before-write: a read in the same cycle as an update returns the old value.
  - Back-to-back rd_req on consecutive cycles is allowed; rd_vld is then high on consecutive cycles.
  - rd_addr >= NCH: rd_data=0 and rd_err=1, with rd_vld still asserted.
  - rd_vld=0 in any cycle without a preceding rd_req; rd_data holds its last value.
- Channels are fully independent; simultaneous samples on all channels are legal every cycle.

Optional Feature:
- Macro PWR_MON_TOTAL_EN.
- Defined:
  - Adds an aggregate counter tot (CW bits, saturating) that adds the sum of all channels' t values in the same cycle.
  - The per-cycle sum is up to NCH*W; size it at clog2(NCH*W+1) bits.
  - tot is read at rd_addr == NCH, is cleared by clr and reset, and does not drive any sat bit.
  - Requires 2**AW > NCH+1.
- Undefined: no aggregate logic; address NCH returns rd_err=1 like any other out-of-range address.

Decomposition:
- Shared package/header `pwr_mon_defs`:
  - default parameter values;
  - the counter saturation constant `PWR_MAX_CNT`;
  - the read-error data value (0).
- One natural sub-module, `pwr_toggle_cnt`: one channel's prev/primed/cnt/sat slice with popcount and saturating add, instantiated NCH times with a generate loop.
- The top level holds the read mux, the rd_vld/rd_err pipeline flop and the optional total.

Test Plan:
1. Reset and priming: release rst; sample ch0 = 8'hFF, then 8'h00, then 8'hCC. Read ch0 -> rd_vld one cycle later, rd_data=12 (the first sample only primes; 8 toggles + 4 toggles). Other channels read 0, sat=0.
2. Disable window: enb=0 while ch1 is presented 8'hAB and 8'h25; then enb=1 with 8'h0F after a primed 8'h00. Read ch1 -> 4; the disabled samples are not counted and prev is unchanged.
3. Saturation: CW=4, ch2 alternating 8'h00/8'hFF for 3 accepted toggles. Read ch2 -> 15 and sat[2]=1. Further toggles keep 15. clr -> 0 and sat[2]=0.
4. Simultaneous events: on the same edge a ch3 update (+8), rd_req for ch3 and clr=0 -> read returns the old value; the next read returns old+8. In a separate cycle, clr with rd_req -> returns the pre-clear value, and the next read returns 0.
5. Address error and back-to-back reads: rd_addr=0,1,5 on consecutive cycles with NCH=4 -> three consecutive rd_vld pulses; the third has rd_err=1 and rd_data=0.
6. With PWR_MON_TOTAL_EN defined: 8'hFF->8'h00 on ch0 and 8'h00->8'h0F on ch1 in the same cycle. Read addr 4 -> 12. Without the macro, the same read gives rd_err=1.

Source files
------------

// File: rtl/pwr_mon_defs_pkg.sv
// pwr_mon_defs_pkg
//   Shared definitions for the transition-count power monitor.
//   - Default parameter values (channel count, sample width, counter width,
//     read-address width).
//   - PWR_MAX_CNT: all-ones saturation pattern; a module with counter width CW
//     takes its low CW bits (CW may be at most 64).
//   - RD_ERR_DATA: value returned on rd_data for an out-of-range read.
//   Optional build macro used by the monitor: PWR_MON_TOTAL_EN (aggregate
//   counter readable at address NCH).
package pwr_mon_defs_pkg;

  localparam int PWR_NCH_DEF = 4;
  localparam int PWR_W_DEF   = 8;
  localparam int PWR_CW_DEF  = 32;
  localparam int PWR_AW_DEF  = 3;

  localparam logic [63:0] PWR_MAX_CNT = '1;

  localparam int RD_ERR_DATA = 0;

endpackage

// File: rtl/pwr_toggle_cnt.sv
// pwr_toggle_cnt
//   One monitored channel: previous-sample register, primed bit, saturating
//   toggle counter and sticky saturation flag.
//   Ports:
//     clk, rst      clock, asynchronous active-low reset
//     enb, vld      global enable and this channel's sample strobe
//     clr           synchronous clear (wins over a sample in the same cycle)
//     sample        W-bit channel sample
//     cnt           current toggle count (CW bits, saturating)
//     sat           sticky saturation flag
//     toggles       (PWR_MON_TOTAL_EN only) toggles added this cycle, 0 if none
module pwr_toggle_cnt
  import pwr_mon_defs_pkg::*;
#(
  parameter int W  = PWR_W_DEF,
  parameter int CW = PWR_CW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enb,
  input  logic                     vld,
  input  logic                     clr,
  input  logic [W-1:0]             sample,
  output logic [CW-1:0]            cnt,
  output logic                     sat
`ifdef PWR_MON_TOTAL_EN
  ,
  output logic [$clog2(W+1)-1:0]   toggles
`endif
);

  localparam int TW = $clog2(W + 1);
  localparam logic [CW-1:0] MaxCnt = PWR_MAX_CNT[CW-1:0];

  logic [W-1:0]  prevReg;
  logic          primedReg;
  logic [CW-1:0] cntReg;
  logic          satReg;

  logic [W-1:0]  diffBits;
  logic [TW-1:0] togCnt;
  logic [CW:0]   sumWide;
  logic [CW-1:0] cntClamped;
  logic          accept;

  assign accept   = enb && vld && !clr;
  assign diffBits = prevReg ^ sample;

  always_comb begin
    togCnt = '0;
    for (int i = 0; i < W; i++) begin
      togCnt = togCnt + TW'(diffBits[i]);
    end
  end

  // One extra bit catches the carry out so the clamp is exact.
  assign sumWide    = {1'b0, cntReg} + (CW + 1)'(togCnt);
  assign cntClamped = sumWide[CW] ? MaxCnt : sumWide[CW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prevReg   <= '0;
      primedReg <= 1'b0;
      cntReg    <= '0;
      satReg    <= 1'b0;
    end else if (clr) begin
      primedReg <= 1'b0;
      cntReg    <= '0;
      satReg    <= 1'b0;
    end else if (accept) begin
      prevReg   <= sample;
      primedReg <= 1'b1;
      // The first sample after reset/clear only establishes the reference.
      if (primedReg) begin
        cntReg <= cntClamped;
        if (cntClamped == MaxCnt) begin
          satReg <= 1'b1;
        end
      end
    end
  end

  assign cnt = cntReg;
  assign sat = satReg;

`ifdef PWR_MON_TOTAL_EN
  assign toggles = (accept && primedReg) ? togCnt : '0;
`endif

endmodule

// File: rtl/pwr_trans_monitor.sv
// pwr_trans_monitor
//   Per-channel bit-toggle counter for switching-activity power estimation.
//   NCH channels of W bits are watched; each accepted sample adds the number
//   of bits that changed since the previous accepted sample on that channel.
//   Counts are read through a one-cycle-latency addressed port.
//   Ports:
//     clk         clock, all flops rising edge
//     rst         asynchronous active-low reset
//     enb         global count enable
//     sample_vld  per-channel sample strobe (NCH bits)
//     data_in     channel c at [c*W+W-1 : c*W]
//     clr         synchronous clear of all counters, highest priority
//     rd_req      read request pulse; rd_addr selects the channel
//     rd_data     read result, holds between reads
//     rd_vld      one-cycle pulse one cycle after rd_req
//     rd_err      address out of range, qualified by rd_vld
//     sat         sticky per-channel saturation flags
//   Build macro PWR_MON_TOTAL_EN adds an aggregate saturating counter of all
//   channels' toggles, read at rd_addr == NCH (needs 2**AW > NCH+1).
//   Address width must satisfy 2**AW > NCH.
module pwr_trans_monitor
  import pwr_mon_defs_pkg::*;
#(
  parameter int NCH = PWR_NCH_DEF,
  parameter int W   = PWR_W_DEF,
  parameter int CW  = PWR_CW_DEF,
  parameter int AW  = PWR_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enb,
  input  logic [NCH-1:0]     sample_vld,
  input  logic [NCH*W-1:0]   data_in,
  input  logic               clr,
  input  logic               rd_req,
  input  logic [AW-1:0]      rd_addr,
  output logic [CW-1:0]      rd_data,
  output logic               rd_vld,
  output logic               rd_err,
  output logic [NCH-1:0]     sat
);

  logic [CW-1:0] cntArr [NCH];
  logic [CW-1:0] muxData;
  logic          muxHit;
  logic [CW-1:0] rdDataReg;
  logic          rdVldReg;
  logic          rdErrReg;

`ifdef PWR_MON_TOTAL_EN
  localparam int TW  = $clog2(W + 1);
  localparam int TSW = $clog2(NCH * W + 1);
  localparam logic [CW-1:0] MaxCnt = PWR_MAX_CNT[CW-1:0];

  logic [TW-1:0]  togArr [NCH];
  logic [TSW-1:0] cycSum;
  logic [CW:0]    totWide;
  logic [CW-1:0]  totReg;
`endif

  for (genvar gi = 0; gi < NCH; gi++) begin : gChan
    pwr_toggle_cnt #(
      .W  (W),
      .CW (CW)
    ) uChan (
      .clk     (clk),
      .rst     (rst),
      .enb     (enb),
      .vld     (sample_vld[gi]),
      .clr     (clr),
      .sample  (data_in[gi*W +: W]),
      .cnt     (cntArr[gi]),
      .sat     (sat[gi])
`ifdef PWR_MON_TOTAL_EN
      ,
      .toggles (togArr[gi])
`endif
    );
  end

`ifdef PWR_MON_TOTAL_EN
  always_comb begin
    cycSum = '0;
    for (int c = 0; c < NCH; c++) begin
      cycSum = cycSum + TSW'(togArr[c]);
    end
  end

  assign totWide = {1'b0, totReg} + (CW + 1)'(cycSum);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      totReg <= '0;
    end else if (clr) begin
      totReg <= '0;
    end else begin
      totReg <= totWide[CW] ? MaxCnt : totWide[CW-1:0];
    end
  end
`endif

  // Read mux samples the counters before this edge's update, so a read in
  // the same cycle as an update or a clear returns the old value.
  always_comb begin
    muxData = CW'(RD_ERR_DATA);
    muxHit  = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (rd_addr == AW'(c)) begin
        muxData = cntArr[c];
        muxHit  = 1'b1;
      end
    end
`ifdef PWR_MON_TOTAL_EN
    if (rd_addr == AW'(NCH)) begin
      muxData = totReg;
      muxHit  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdDataReg <= '0;
      rdVldReg  <= 1'b0;
      rdErrReg  <= 1'b0;
    end else begin
      rdVldReg <= rd_req;
      if (rd_req) begin
        rdDataReg <= muxData;
        rdErrReg  <= !muxHit;
      end else begin
        rdErrReg  <= 1'b0;
      end
    end
  end

  assign rd_data = rdDataReg;
  assign rd_vld  = rdVldReg;
  assign rd_err  = rdErrReg;

endmodule
